async_fifo_wr_ctrl: RTL and testbench

Write-domain half of a dual-clock FIFO, running on wr_clk.
- Owns the binary/Gray write pointer and the write-port address/enable for an external dual-port memory.
- Brings the read-side Gray pointer into wr_clk through a 2-flop synchronizer and derives full, almost_full and fill level from it.
- Pairs with a read-domain controller, which consumes wr_gray_ptr through its own synchronizer.

---
 rtl/async_fifo_wr_ctrl.sv | 93 +++++++++
 tb/tb_async_fifo_wr_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of a dual-clock FIFO: write pointer, read-pointer synchronizer, full/level flags.
// Optional sticky overflow flag is built when ASYNC_FIFO_WR_OVERFLOW_EN is defined.
module async_fifo_wr_ctrl #(
    parameter int ADDR_W       = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic              wr_clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rd_gray_ptr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   wr_gray_ptr,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
    ,
    output logic              overflow
`endif
);
    localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W + 1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] r_wr_bin;
    logic [ADDR_W:0] r_wr_gray;
    logic [ADDR_W:0] r_rd_sync1;
    logic [ADDR_W:0] r_rd_sync2;
    logic [ADDR_W:0] w_wr_bin_next;
    logic [ADDR_W:0] w_rd_bin;
    logic [ADDR_W:0] w_full_cmp;
    logic            w_accept;

    // Handshake: wr_en is the request (valid) and ~full the ready; a write transfers
    // on a wr_clk edge where both are high, and wr_en may change on any cycle.
    assign w_accept      = wr_en & ~full;
    assign w_wr_bin_next = r_wr_bin + PTR_ONE;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rd_bin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            w_rd_bin[i] = ^(r_rd_sync2 >> i);
        end
    end

    // Full pointer is half a Gray cycle ahead: top two bits inverted, rest equal.
    generate
        if (ADDR_W == 1) begin : g_full_cmp_narrow
            assign w_full_cmp = ~r_rd_sync2;
        end else begin : g_full_cmp_wide
            assign w_full_cmp = {~r_rd_sync2[ADDR_W:ADDR_W-1], r_rd_sync2[ADDR_W-2:0]};
        end
    endgenerate

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            r_wr_bin   <= '0;
            r_wr_gray  <= '0;
            r_rd_sync1 <= '0;
            r_rd_sync2 <= '0;
        end else begin
            r_rd_sync1 <= rd_gray_ptr;
            r_rd_sync2 <= r_rd_sync1;
            if (w_accept) begin
                r_wr_bin  <= w_wr_bin_next;
                r_wr_gray <= w_wr_bin_next ^ (w_wr_bin_next >> 1);
            end
        end
    end

`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (wr_en && full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

    assign full        = (r_wr_gray == w_full_cmp);
    assign wr_level    = r_wr_bin - w_rd_bin;
    assign almost_full = (wr_level >= AFULL_LVL);
    assign mem_we      = w_accept;
    assign wr_addr     = r_wr_bin[ADDR_W-1:0];
    assign wr_gray_ptr = r_wr_gray;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl: directed fill/full/drain/wrap/reset cases, then a
// dual-clock random run against a read-side model and a data scoreboard.
`timescale 1ns/1ps
module tb_async_fifo_wr_ctrl;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              wr_clk;
    logic              rd_clk;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W:0]   rd_gray_ptr;
    logic              mem_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wr_gray_ptr;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_level;
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
    logic              overflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard and read-side model state.
    logic [15:0]     exp_q[$];
    logic [15:0]     mem [DEPTH];
    logic [15:0]     wdata;
    logic [15:0]     got;
    logic [15:0]     expv;
    logic [ADDR_W:0] rd_bin;
    logic [ADDR_W:0] ws1;
    logic [ADDR_W:0] ws2;
    logic            rd_run;
    int              n_wr;
    int              n_rd;
    int              gray_seq[8] = '{1, 3, 2, 6, 7, 5, 4, 12};

    async_fifo_wr_ctrl #(.ADDR_W(ADDR_W), .AFULL_THRESH(6)) dut (
        .wr_clk      (wr_clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_gray_ptr (rd_gray_ptr),
        .mem_we      (mem_we),
        .wr_addr     (wr_addr),
        .wr_gray_ptr (wr_gray_ptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level)
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    // Clocks: 100 MHz write, ~37 MHz read, offset so edges never coincide.
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    initial begin
        rd_clk = 1'b0;
        #3.7;
        forever #13.5 rd_clk = ~rd_clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    // Read-side model: own synchronizer of wr_gray_ptr, pops the scoreboard on each read.
    initial begin
        forever begin
            @(posedge rd_clk);
            if (rd_run) begin
                if (rd_gray_ptr != ws2 && $urandom_range(0, 9) < 8) begin
                    got = mem[rd_bin[ADDR_W-1:0]];
                    if (exp_q.size() == 0) begin
                        check("rd_underflow", 32'd1, 32'd0);
                    end else begin
                        expv = exp_q.pop_front();
                        check("rd_data", 32'(got), 32'(expv));
                    end
                    rd_bin      = rd_bin + 1'b1;
                    rd_gray_ptr = rd_bin ^ (rd_bin >> 1);
                    n_rd++;
                end
                ws2 = ws1;
                ws1 = wr_gray_ptr;
            end
        end
    end

    initial begin
        rst         = 1'b1;
        wr_en       = 1'b1;
        rd_gray_ptr = '0;
        rd_run      = 1'b0;
        rd_bin      = '0;
        ws1         = '0;
        ws2         = '0;
        wdata       = 16'h1000;
        n_wr        = 0;
        n_rd        = 0;

        // Reset held with a write request pending.
        tick();
        check("rst_gray", 32'(wr_gray_ptr), 32'd0);
        check("rst_level", 32'(wr_level), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd1);
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
        check("rst_ovf", 32'(overflow), 32'd0);
`endif
        rst = 1'b0;

        // Fill from empty with the read pointer held at 0.
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_addr", 32'(wr_addr), 32'(i));
            check("fill_mem_we", 32'(mem_we), 32'd1);
            tick();
            check("fill_gray", 32'(wr_gray_ptr), 32'(gray_seq[i]));
            check("fill_level", 32'(wr_level), 32'(i + 1));
            check("fill_afull", 32'(almost_full), 32'((i + 1) >= 6));
            check("fill_full", 32'(full), 32'(i == DEPTH - 1));
        end
        check("full_mem_we", 32'(mem_we), 32'd0);
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
        check("ovf_before", 32'(overflow), 32'd0);
`endif

        // Writes while full are dropped.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wf_gray", 32'(wr_gray_ptr), 32'd12);
            check("wf_level", 32'(wr_level), 32'd8);
            check("wf_addr", 32'(wr_addr), 32'd0);
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
            check("wf_ovf", 32'(overflow), 32'd1);
`endif
        end

        // One read: full survives one edge, clears on the second.
        wr_en       = 1'b0;
        rd_gray_ptr = 4'd1;
        tick();
        check("drain_full_e1", 32'(full), 32'd1);
        check("drain_level_e1", 32'(wr_level), 32'd8);
        tick();
        check("drain_full_e2", 32'(full), 32'd0);
        check("drain_level_e2", 32'(wr_level), 32'd7);
        check("drain_afull", 32'(almost_full), 32'd1);
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
        check("drain_ovf_sticky", 32'(overflow), 32'd1);
`endif

        // Wrap: reader catches up to 8, writer goes to 12, reader moves to 10.
        rd_gray_ptr = 4'd12;
        tick();
        tick();
        check("wrap_empty_level", 32'(wr_level), 32'd0);
        check("wrap_empty_afull", 32'(almost_full), 32'd0);
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        wr_en = 1'b0;
        check("wrap_level4", 32'(wr_level), 32'd4);
        rd_gray_ptr = 4'd15;
        tick();
        tick();
        check("wrap_gray", 32'(wr_gray_ptr), 32'b1010);
        check("wrap_addr", 32'(wr_addr), 32'd4);
        check("wrap_level", 32'(wr_level), 32'd2);
        check("wrap_full", 32'(full), 32'd0);

        // Asynchronous reset mid-operation clears state without a clock edge.
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_gray", 32'(wr_gray_ptr), 32'd0);
        check("arst_level", 32'(wr_level), 32'd0);
        check("arst_addr", 32'(wr_addr), 32'd0);
`ifdef ASYNC_FIFO_WR_OVERFLOW_EN
        check("arst_ovf", 32'(overflow), 32'd0);
`endif
        rd_gray_ptr = '0;
        tick();
        rst    = 1'b0;
        rd_run = 1'b1;

        // Random dual-clock traffic against the read-side model.
        for (int cyc = 0; cyc < 20000 && n_wr < 1000; cyc++) begin
            @(negedge wr_clk);
            wr_en = ($urandom_range(0, 9) < 7);
            #1;
            if (mem_we) begin
                check("rand_no_write_at_full", 32'((n_wr - n_rd) < DEPTH), 32'd1);
                check("rand_wr_addr", 32'(wr_addr), 32'(n_wr % DEPTH));
                mem[n_wr % DEPTH] = wdata;
                exp_q.push_back(wdata);
                wdata = wdata + 1'b1;
                n_wr++;
            end
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
        check("rand_write_count", 32'(n_wr), 32'd1000);

        for (int cyc = 0; cyc < 5000 && n_rd < n_wr; cyc++) tick();
        check("rand_all_read", 32'(n_rd), 32'(n_wr));
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("rand_end_level", 32'(wr_level), 32'd0);
        check("rand_end_full", 32'(full), 32'd0);
        rd_run = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
